// File: rtl/memory_access_unit.sv
// Byte/half/word load-store sequencer in front of a word-wide RAM with ack timeout.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses abort with Error.
module memory_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ReadMemory,
  input  logic        WriteMemory,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Error,
  output logic        MemRequest,
  output logic        MemWrite,
  output logic [29:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic [3:0]  MemByteEnable,
  input  logic [31:0] MemReadData,
  input  logic        MemAck
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  count_r;
  logic [1:0]  addr_lo_r;
  logic [2:0]  funct3_r;
  logic        write_r;
  logic        accept_s;
  logic        trap_s;
  logic        timeout_s;

  function automatic logic [3:0] store_enable(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  store_enable = 4'b0001 << a;
      3'b001:  store_enable = a[1] ? 4'b1100 : 4'b0011;
      default: store_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  store_data = {4{wd[7:0]}};
      3'b001:  store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'd0, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = w;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  // Byte accesses never trap; halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic misaligned(input logic [2:0] f3, input logic wr, input logic [1:0] a);
    logic is_byte;
    logic is_half;
    is_byte = (f3 == 3'b000) || (!wr && (f3 == 3'b100));
    is_half = (f3 == 3'b001) || (!wr && (f3 == 3'b101));
    if (is_byte) begin
      misaligned = 1'b0;
    end else if (is_half) begin
      misaligned = a[0];
    end else begin
      misaligned = (a != 2'b00);
    end
  endfunction

  assign trap_s = misaligned(Funct3, WriteMemory, Address[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  assign accept_s = (state_r == IDLE) && (ReadMemory || WriteMemory);

  // Next-state logic; MemAck has priority over the timeout on the last counted cycle.
  always_comb begin
    state_next_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = trap_s ? DONE : ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (MemAck) begin
          state_next_s = DONE;
        end else if (count_r == LAST_COUNT) begin
          state_next_s = DONE;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = ACCESS;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs, captured request fields and the wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      ReadData      <= 32'd0;
      Ready         <= 1'b0;
      Busy          <= 1'b0;
      Error         <= 1'b0;
      MemRequest    <= 1'b0;
      MemWrite      <= 1'b0;
      MemAddress    <= 30'd0;
      MemWriteData  <= 32'd0;
      MemByteEnable <= 4'd0;
      count_r       <= 8'd0;
      addr_lo_r     <= 2'd0;
      funct3_r      <= 3'd0;
      write_r       <= 1'b0;
    end else begin
      Ready <= (state_next_s == DONE);
      Busy  <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_lo_r    <= Address[1:0];
            funct3_r     <= Funct3;
            write_r      <= WriteMemory;
            count_r      <= 8'd0;
            Error        <= trap_s;
            MemAddress   <= Address[31:2];
            MemWriteData <= store_data(Funct3, WriteData);
            if (trap_s) begin
              ReadData <= 32'd0;
            end else begin
              MemRequest    <= 1'b1;
              MemWrite      <= WriteMemory;
              MemByteEnable <= WriteMemory ? store_enable(Funct3, Address[1:0]) : 4'd0;
            end
          end
        end
        ACCESS: begin
          if (MemAck || timeout_s) begin
            MemRequest    <= 1'b0;
            MemWrite      <= 1'b0;
            MemByteEnable <= 4'd0;
          end
          if (MemAck) begin
            if (!write_r) begin
              ReadData <= load_extract(funct3_r, addr_lo_r, MemReadData);
            end
          end else if (timeout_s) begin
            Error    <= 1'b1;
            ReadData <= 32'd0;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed vector table, hand-written
// corner sequences and random accesses checked against an arithmetic reference model.
module tb_memory_access_unit;

  localparam int TB_TIMEOUT = 8;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ReadMemory, WriteMemory;
  logic [31:0] Address, WriteData;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic        Ready, Busy, Error;
  logic        MemRequest, MemWrite;
  logic [29:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [3:0]  MemByteEnable;
  logic [31:0] MemReadData;
  logic        MemAck;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd = 32'd0;

  memory_access_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .ReadMemory(ReadMemory), .WriteMemory(WriteMemory),
    .Address(Address), .WriteData(WriteData), .Funct3(Funct3), .ReadData(ReadData),
    .Ready(Ready), .Busy(Busy), .Error(Error), .MemRequest(MemRequest), .MemWrite(MemWrite),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemByteEnable(MemByteEnable),
    .MemReadData(MemReadData), .MemAck(MemAck)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes from the RV32I funct3 rules.
  function automatic int model_size(input bit wr, input logic [2:0] f3);
    if (f3 == 3'd0 || (!wr && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!wr && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = model_size(wr, f3);
    if (!wr) return 4'd0;
    if (sz == 1) return 4'(1 << (addr % 32'd4));
    if (sz == 2) return 4'(3 << (2 * ((addr / 32'd2) % 32'd2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = model_size(1'b1, f3);
    if (sz == 1) return (wd % 32'd256) * 32'h01010101;
    if (sz == 2) return (wd % 32'd65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = model_size(1'b0, f3);
    if (sz == 1) begin
      v = (rd >> (8 * (addr % 32'd4))) % 32'd256;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = (rd >> (16 * ((addr / 32'd2) % 32'd2))) % 32'd65536;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic bit model_trap(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = model_size(wr, f3);
    return TRAP_EN && ((sz == 2 && (addr % 32'd2) != 0) || (sz == 4 && (addr % 32'd4) != 0));
  endfunction

  // One complete access; ack_delay >= TB_TIMEOUT means MemAck is never given.
  task automatic run_access(input string name, input bit wr, input bit both, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                            input int ack_delay, input logic [31:0] exp_load,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    bit trap, done, acked;
    int cyc;
    trap = model_trap(wr, f3, addr);
    WriteMemory = wr; ReadMemory = !wr || both;
    Address = addr; WriteData = wd; Funct3 = f3;
    @(negedge clock);
    WriteMemory = 1'b0; ReadMemory = 1'b0;
    check({name, " busy"}, Busy, 1);
    if (trap) begin
      check({name, " trap req"}, MemRequest, 0);
      check({name, " trap ready"}, Ready, 1);
      check({name, " trap error"}, Error, 1);
      check({name, " trap rdata"}, ReadData, 0);
      model_rd = 32'd0;
    end else begin
      check({name, " req"}, MemRequest, 1);
      check({name, " memwrite"}, MemWrite, wr);
      check({name, " memaddr"}, MemAddress, addr >> 2);
      check({name, " be"}, MemByteEnable, exp_be);
      check({name, " error clr"}, Error, 0);
      if (wr) check({name, " wdata"}, MemWriteData, exp_wd);
      done = 0; acked = 0; cyc = 0;
      while (!done) begin
        MemAck = (cyc == ack_delay);
        MemReadData = (cyc == ack_delay) ? rd : $urandom;
        @(negedge clock);
        MemAck = 1'b0;
        if (cyc == ack_delay) begin
          acked = 1; done = 1;
        end else if (cyc == TB_TIMEOUT - 1) begin
          done = 1;
        end
        if (!done) begin
          check({name, " wait ready"}, Ready, 0);
          check({name, " wait req"}, MemRequest, 1);
          check({name, " wait addr"}, MemAddress, addr >> 2);
        end
        cyc++;
      end
      check({name, " ready"}, Ready, 1);
      check({name, " req drop"}, MemRequest, 0);
      if (acked) begin
        if (!wr) model_rd = exp_load;
        check({name, " error"}, Error, 0);
      end else begin
        model_rd = 32'd0;
        check({name, " timeout error"}, Error, 1);
      end
      check({name, " rdata"}, ReadData, model_rd);
    end
    @(negedge clock);
    check({name, " ready pulse"}, Ready, 0);
    check({name, " idle"}, Busy, 0);
  endtask

  typedef struct {
    string       name;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd;
    int          dly;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1; ReadMemory = 1'b0; WriteMemory = 1'b0; Address = 32'd0; WriteData = 32'd0;
    Funct3 = 3'd0; MemReadData = 32'd0; MemAck = 1'b0;

    vecs.push_back('{"sw_deadbeef", 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 3, 32'h0, 4'hF, 32'hDEADBEEF});
    vecs.push_back('{"lb_103",      0, 3'd0, 32'h103, 32'h0, 32'h80112233, 1, 32'hFFFFFF80, 4'h0, 32'h0});
    vecs.push_back('{"lbu_103",     0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 32'h00000080, 4'h0, 32'h0});
    vecs.push_back('{"sh_102",      1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 2, 32'h0, 4'hC, 32'hABCDABCD});
    vecs.push_back('{"lw_101",      0, 3'd2, 32'h101, 32'h0, 32'hCAFEF00D, 2, 32'hCAFEF00D, 4'h0, 32'h0});
    vecs.push_back('{"lh_102",      0, 3'd1, 32'h102, 32'h0, 32'h80112233, 1, 32'hFFFF8011, 4'h0, 32'h0});
    vecs.push_back('{"lhu_100",     0, 3'd5, 32'h100, 32'h0, 32'h80112233, 1, 32'h00002233, 4'h0, 32'h0});
    vecs.push_back('{"sb_101",      1, 3'd0, 32'h101, 32'h000000AB, 32'h0, 0, 32'h0, 4'h2, 32'hABABABAB});
    vecs.push_back('{"lb_pos",      0, 3'd0, 32'h100, 32'h0, 32'h0000007F, 0, 32'h0000007F, 4'h0, 32'h0});
    vecs.push_back('{"lh_103",      0, 3'd1, 32'h103, 32'h0, 32'h8001FFFF, 1, 32'hFFFF8001, 4'h0, 32'h0});
    vecs.push_back('{"ld_timeout",  0, 3'd2, 32'h200, 32'h0, 32'h12345678, 100, 32'h0, 4'h0, 32'h0});
    vecs.push_back('{"sw_lastack",  1, 3'd2, 32'h204, 32'h00000001, 32'h0, TB_TIMEOUT - 1, 32'h0, 4'hF, 32'h00000001});
    vecs.push_back('{"s_code3",     1, 3'd3, 32'h301, 32'h11223344, 32'h0, 0, 32'h0, 4'hF, 32'h11223344});
    vecs.push_back('{"l_code3",     0, 3'd3, 32'h302, 32'h0, 32'h55AA55AA, 0, 32'h55AA55AA, 4'h0, 32'h0});

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset busy", Busy, 0);
    check("reset ready", Ready, 0);
    check("reset error", Error, 0);
    check("reset req", MemRequest, 0);
    check("reset memwrite", MemWrite, 0);
    check("reset be", MemByteEnable, 0);
    check("reset rdata", ReadData, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_access(vecs[i].name, vecs[i].wr, 1'b0, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd,
                 vecs[i].dly, model_trap(vecs[i].wr, vecs[i].f3, vecs[i].addr) ? 32'h0 : vecs[i].exp_rd,
                 vecs[i].exp_be, vecs[i].exp_wd);
    end

    // Both strobes: the store wins.
    run_access("both_strobes", 1'b1, 1'b1, 3'd2, 32'h40, 32'h00000005, 32'h0, 1, 32'h0, 4'hF, 32'h00000005);

    // MemAck while idle must not produce a completion.
    MemAck = 1'b1; MemReadData = 32'hFFFFFFFF;
    @(negedge clock);
    MemAck = 1'b0;
    check("idle ack ready", Ready, 0);
    check("idle ack busy", Busy, 0);
    check("idle ack rdata", ReadData, model_rd);

    // Strobes during ACCESS and DONE are ignored.
    ReadMemory = 1'b1; Address = 32'h500; Funct3 = 3'd2;
    @(negedge clock);
    ReadMemory = 1'b0; WriteMemory = 1'b1; Address = 32'h900;
    @(negedge clock);
    check("busy ign addr", MemAddress, 30'h140);
    check("busy ign write", MemWrite, 0);
    MemAck = 1'b1; MemReadData = 32'h12345678;
    @(negedge clock);
    MemAck = 1'b0;
    check("busy ign ready", Ready, 1);
    check("busy ign rdata", ReadData, 32'h12345678);
    model_rd = 32'h12345678;
    @(negedge clock);
    WriteMemory = 1'b0;
    check("busy ign idle", Busy, 0);
    check("busy ign noreq", MemRequest, 0);
    @(negedge clock);
    check("busy ign stays idle", Busy, 0);

    // Reset mid-ACCESS abandons the access; a late MemAck is ignored.
    ReadMemory = 1'b1; Address = 32'h600; Funct3 = 3'd2;
    @(negedge clock);
    ReadMemory = 1'b0;
    check("rst mid req", MemRequest, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_rd = 32'd0;
    check("rst mid req drop", MemRequest, 0);
    check("rst mid busy", Busy, 0);
    check("rst mid ready", Ready, 0);
    check("rst mid rdata", ReadData, 0);
    MemAck = 1'b1; MemReadData = 32'hA5A5A5A5;
    @(negedge clock);
    MemAck = 1'b0;
    check("late ack ready", Ready, 0);
    check("late ack busy", Busy, 0);
    check("late ack rdata", ReadData, 0);

    // Random accesses against the reference model.
    for (int i = 0; i < 60; i++) begin
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rd;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; rd = $urandom;
      run_access("rand", wr, 1'b0, f3, addr, wd, rd, $urandom_range(0, TB_TIMEOUT + 1),
                 model_trap(wr, f3, addr) ? 32'h0 : model_load(f3, addr, rd),
                 model_be(wr, f3, addr), model_wd(f3, wd));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for MemAck before aborting (range 2..255).
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ReadMemory, input, 1: load strobe from the multicycle control.
REQ-005 SHALL have port WriteMemory, input, 1: store strobe from the multicycle control.
REQ-006 SHALL have port Address, input, 32: byte address of the access.
REQ-007 SHALL have port WriteData, input, 32: store data, right-aligned.
REQ-008 SHALL have port Funct3, input, 3: access size/sign (RV32I encoding).
REQ-009 SHALL have port ReadData, output, 32: aligned, extended load result.
REQ-010 SHALL have port Ready, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port Busy, output, 1: access in progress.
REQ-012 SHALL have port Error, output, 1: sticky-until-next-access abort flag.
REQ-013 SHALL have port MemRequest, output, 1: request to word RAM.
REQ-014 SHALL have port MemWrite, output, 1: request is a write.
REQ-015 SHALL have port MemAddress, output, 30: word address (Address bits 31..2).
REQ-016 SHALL have port MemWriteData, output, 32: lane-replicated store data.
REQ-017 SHALL have port MemByteEnable, output, 4: byte lanes written.
REQ-018 SHALL have port MemReadData, input, 32: RAM read word.
REQ-019 SHALL have port MemAck, input, 1: RAM completion, one cycle.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DONE.
REQ-021 IDLE: on WriteMemory or ReadMemory high, SHALL register Address, WriteData, Funct3, direction and go to ACCESS next cycle; WriteMemory wins if both high.
REQ-022 ACCESS: SHALL hold MemRequest=1 and all Mem* outputs stable until MemAck; on MemAck go to DONE.
REQ-023 SHALL count cycles in ACCESS; on reaching TIMEOUT_CYCLES without MemAck, drop MemRequest, set Error=1, ReadData=0, go to DONE.
REQ-024 DONE: SHALL assert Ready=1 for exactly one cycle, then return to IDLE; minimum latency strobe-to-Ready = 2 cycles plus RAM wait.
REQ-025 Busy SHALL be 1 in ACCESS and DONE; strobes SHALL be ignored while Busy.
REQ-026 Error SHALL clear when the next access is accepted.
REQ-027 Store lanes: SB -> enable 0001 shifted by Address[1:0], byte replicated x4; SH -> 0011 shifted by 2*Address[1], half replicated x2; SW and other codes -> 1111, word as is.
REQ-028 Load extraction on MemAck: LB/LBU select byte Address[1:0], LH/LHU select half Address[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW and undefined codes pass word.
REQ-029 ReadData SHALL be registered and hold its value until the next load completes; stores leave it unchanged.
REQ-030 MemAck in IDLE or DONE SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE, MemRequest=0, MemWrite=0, MemByteEnable=0, Ready=0, Busy=0, Error=0, ReadData=0, counter=0, effective next edge, including mid-ACCESS (abandoned access, no Ready).

Configuration
REQ-032 Macro MISALIGN_TRAP_EN: when defined, halfword access with Address[0]=1 or word access with Address[1:0]!=0 SHALL skip ACCESS (no MemRequest), enter DONE next cycle with Error=1, ReadData=0, no write; when undefined, offending low address bits SHALL be ignored (halfword uses Address[1], word ignores Address[1:0]).

Verification
REQ-033 SW 0xDEADBEEF at 0x100, MemAck after 3 cycles -> MemAddress=0x40, MemByteEnable=1111, Ready 1 cycle after MemAck.
REQ-034 LB at 0x103, MemReadData=0x80112233 -> ReadData=0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH 0x1234ABCD at 0x102 -> MemByteEnable=1100, MemWriteData=0xABCDABCD.
REQ-036 Load, MemAck never asserted, TIMEOUT_CYCLES=8 -> MemRequest drops after 8 cycles, Error=1, Ready pulse, ReadData=0.
REQ-037 LW at 0x101 -> with MISALIGN_TRAP_EN: no MemRequest, Error=1 in 2 cycles; without: word from 0x100 returned.
REQ-038 reset asserted mid-ACCESS, then late MemAck -> MemRequest=0 next cycle, no Ready, state IDLE.
